// File: rtl/key_debounce.sv
// Four-channel active-low push-button debouncer with press/release strobes.
// Define KEY_DEBOUNCE_LONG_EN to enable the one-shot long-press strobe.
module key_debounce #(
    parameter int unsigned DEBOUNCE_CNT = 1_000_000,
    parameter int unsigned LONG_CNT     = 50_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] key_n,
    output logic [3:0] key_stable,
    output logic [3:0] key_press,
    output logic [3:0] key_release,
    output logic [3:0] key_long
);

`ifdef KEY_DEBOUNCE_LONG_EN
    localparam int unsigned CW = $clog2(LONG_CNT + 1);
`else
    localparam int unsigned CW = $clog2(DEBOUNCE_CNT + 1);
`endif

    typedef enum logic [1:0] {
        RELEASED    = 2'd0,
        PRESS_CHK   = 2'd1,
        PRESSED     = 2'd2,
        RELEASE_CHK = 2'd3
    } state_e;

    if (DEBOUNCE_CNT < 2 || LONG_CNT <= DEBOUNCE_CNT) begin : g_bad_cfg
        $error("key_debounce: DEBOUNCE_CNT must be >= 2 and below LONG_CNT");
    end

    logic [3:0]    sync1_q, sync2_q;
    state_e        state_q [4];
    state_e        state_d [4];
    logic [CW-1:0] cnt_q   [4];
    logic [CW-1:0] cnt_d   [4];
    logic [3:0]    stable_q, stable_d;
    logic [3:0]    press_q, press_d;
    logic [3:0]    release_q, release_d;
    logic [3:0]    long_q, long_d;
`ifdef KEY_DEBOUNCE_LONG_EN
    // Remembers that the long strobe already fired during this hold.
    logic [3:0]    done_q, done_d;
`endif

    // Per-channel next-state, counter and strobe logic.
    always_comb begin
        stable_d  = stable_q;
        press_d   = 4'b0000;
        release_d = 4'b0000;
        long_d    = 4'b0000;
`ifdef KEY_DEBOUNCE_LONG_EN
        done_d    = done_q;
`endif
        for (int i = 0; i < 4; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                RELEASED: begin
                    cnt_d[i] = '0;
                    if (!sync2_q[i]) begin
                        state_d[i] = PRESS_CHK;
                    end else begin
                        state_d[i] = RELEASED;
                    end
                end
                PRESS_CHK: begin
                    if (sync2_q[i]) begin
                        state_d[i] = RELEASED;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CW'(DEBOUNCE_CNT - 1)) begin
                        state_d[i]  = PRESSED;
                        cnt_d[i]    = '0;
                        stable_d[i] = 1'b0;
                        press_d[i]  = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CW'(1);
                    end
                end
                PRESSED: begin
                    if (sync2_q[i]) begin
                        state_d[i] = RELEASE_CHK;
                        cnt_d[i]   = '0;
                    end else begin
`ifdef KEY_DEBOUNCE_LONG_EN
                        // Saturating hold timer; the strobe fires once per hold.
                        if (cnt_q[i] != CW'(LONG_CNT - 1)) begin
                            cnt_d[i] = cnt_q[i] + CW'(1);
                        end else begin
                            cnt_d[i] = cnt_q[i];
                        end
                        if (cnt_q[i] == CW'(LONG_CNT - 1) && !done_q[i]) begin
                            long_d[i] = 1'b1;
                            done_d[i] = 1'b1;
                        end else begin
                            long_d[i] = 1'b0;
                        end
`else
                        cnt_d[i] = '0;
`endif
                    end
                end
                RELEASE_CHK: begin
                    if (!sync2_q[i]) begin
                        state_d[i] = PRESSED;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CW'(DEBOUNCE_CNT - 1)) begin
                        state_d[i]   = RELEASED;
                        cnt_d[i]     = '0;
                        stable_d[i]  = 1'b1;
                        release_d[i] = 1'b1;
`ifdef KEY_DEBOUNCE_LONG_EN
                        done_d[i]    = 1'b0;
`endif
                    end else begin
                        cnt_d[i] = cnt_q[i] + CW'(1);
                    end
                end
                default: begin
                    state_d[i] = RELEASED;
                    cnt_d[i]   = '0;
                end
            endcase
        end
    end

    // Synchroniser, FSM state, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= 4'hF;
            sync2_q   <= 4'hF;
            stable_q  <= 4'hF;
            press_q   <= 4'h0;
            release_q <= 4'h0;
            long_q    <= 4'h0;
`ifdef KEY_DEBOUNCE_LONG_EN
            done_q    <= 4'h0;
`endif
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= RELEASED;
                cnt_q[i]   <= '0;
            end
        end else begin
            sync1_q   <= key_n;
            sync2_q   <= sync1_q;
            stable_q  <= stable_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
`ifdef KEY_DEBOUNCE_LONG_EN
            done_q    <= done_d;
`endif
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    assign key_stable  = stable_q;
    assign key_press   = press_q;
    assign key_release = release_q;
    assign key_long    = long_q;

endmodule

// File: tb/tb_key_debounce.sv
// Directed self-checking bench for key_debounce (DEBOUNCE_CNT=4, LONG_CNT=20).
module tb_key_debounce;

    logic       clk;
    logic       rst_n;
    logic [3:0] key_n;
    logic [3:0] key_stable;
    logic [3:0] key_press;
    logic [3:0] key_release;
    logic [3:0] key_long;

    int n_checks;
    int n_errors;

    key_debounce #(
        .DEBOUNCE_CNT(4),
        .LONG_CNT    (20)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_n      (key_n),
        .key_stable (key_stable),
        .key_press  (key_press),
        .key_release(key_release),
        .key_long   (key_long)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag, input logic [3:0] stable_exp);
        check({tag, "_stable"},  key_stable,  stable_exp);
        check({tag, "_press"},   key_press,   4'h0);
        check({tag, "_release"}, key_release, 4'h0);
        check({tag, "_long"},    key_long,    4'h0);
    endtask

    // Step n edges: quiet before edge n, strobes at edge n, quiet again at n+1.
    task automatic expect_after(input string tag, input int n,
                                input logic [3:0] press_exp, input logic [3:0] rel_exp,
                                input logic [3:0] st_before, input logic [3:0] st_after);
        for (int k = 1; k < n; k++) begin
            step();
            check_idle({tag, "_wait"}, st_before);
        end
        step();
        check({tag, "_press"},   key_press,   press_exp);
        check({tag, "_release"}, key_release, rel_exp);
        check({tag, "_stable"},  key_stable,  st_after);
        check({tag, "_long"},    key_long,    4'h0);
        step();
        check_idle({tag, "_after"}, st_after);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        key_n    = 4'hF;

        // Reset held while pins toggle randomly.
        for (int k = 0; k < 10; k++) begin
            key_n = 4'($urandom_range(0, 15));
            step();
            check_idle("reset_hold", 4'hF);
        end
        key_n = 4'hF;
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            check_idle("post_reset", 4'hF);
        end

        // Clean press and release on key 0.
        key_n = 4'hE;
        expect_after("clean_press", 7, 4'h1, 4'h0, 4'hF, 4'hE);
        key_n = 4'hF;
        expect_after("clean_release", 7, 4'h0, 4'h1, 4'hE, 4'hF);

        // Bounce train on key 1, then a steady press.
        for (int r = 0; r < 5; r++) begin
            key_n = 4'hD;
            for (int k = 0; k < 3; k++) begin
                step();
                check_idle("bounce_low", 4'hF);
            end
            key_n = 4'hF;
            step();
            check_idle("bounce_high", 4'hF);
        end
        key_n = 4'hD;
        expect_after("bounce_press", 7, 4'h2, 4'h0, 4'hF, 4'hD);
        key_n = 4'hF;
        expect_after("bounce_release", 7, 4'h0, 4'h2, 4'hD, 4'hF);

        // Keys 2 and 3 pressed on the same edge.
        key_n = 4'b0011;
        expect_after("simul_press", 7, 4'hC, 4'h0, 4'hF, 4'h3);
        key_n = 4'hF;
        expect_after("simul_release", 7, 4'h0, 4'hC, 4'h3, 4'hF);

        // Long hold on key 2: press strobe at edge 7, long strobe 20 edges later.
        key_n = 4'hB;
        expect_after("long_press", 7, 4'h4, 4'h0, 4'hF, 4'hB);
`ifdef KEY_DEBOUNCE_LONG_EN
        for (int k = 0; k < 18; k++) begin
            step();
            check_idle("long_wait", 4'hB);
        end
        step();
        check("long_pulse", key_long, 4'h4);
        check("long_stable", key_stable, 4'hB);
        for (int k = 0; k < 100; k++) begin
            step();
            check_idle("long_norepeat", 4'hB);
        end
`else
        for (int k = 0; k < 120; k++) begin
            step();
            check_idle("long_disabled", 4'hB);
        end
`endif
        key_n = 4'hF;
        expect_after("long_release", 7, 4'h0, 4'h4, 4'hB, 4'hF);

        // Reset while key 3 is mid-check (cnt=2 after edge 5).
        key_n = 4'h7;
        for (int k = 0; k < 5; k++) begin
            step();
            check_idle("rst_mid_pre", 4'hF);
        end
        rst_n = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            check_idle("rst_mid_hold", 4'hF);
        end
        rst_n = 1'b1;
        expect_after("rst_mid_press", 7, 4'h8, 4'h0, 4'hF, 4'h7);
        key_n = 4'hF;
        expect_after("rst_mid_release", 7, 4'h0, 4'h8, 4'h7, 4'hF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/key_debounce.md
# key_debounce

Four-channel push-button conditioner sitting directly upstream of the LED pattern controller. It synchronises the raw active-low `key[3:0]` pins to `clk` and rejects contact bounce with a per-key state machine and counter. It delivers a clean active-low level bus with the same encoding as the pins, so the downstream `case (key)` decode is unchanged. It also delivers single-cycle press/release strobes and an optional long-press strobe.

## Interface
Parameters:
- `DEBOUNCE_CNT`, default 1_000_000: cycles the synchronised input must hold a new level before it is accepted (20 ms at 50 MHz). Must be ≥ 2.
- `LONG_CNT`, default 50_000_000: cycles in PRESSED before `key_long` fires (1 s at 50 MHz). Must be > `DEBOUNCE_CNT`.

Ports:
- `clk` input 1: system clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `key_n` input 4: raw button pins, active-low (0 = pressed), asynchronous to `clk`.
- `key_stable` output 4: debounced level, active-low, bit i tracks `key_n[i]`.
- `key_press` output 4: 1-cycle pulse on the accepted press of key i.
- `key_release` output 4: 1-cycle pulse on the accepted release of key i.
- `key_long` output 4: 1-cycle pulse when key i has been held `LONG_CNT` cycles. Tied to 0 without `KEY_DEBOUNCE_LONG_EN`.

## Operation
- Synchroniser: two flops per bit, both reset to 1. The FSM sees only `key_sync` (second stage).
- Channels are fully independent. Each channel has its own FSM and its own counter, `cnt`. The counter width is `$clog2(LONG_CNT+1)` bits, or `$clog2(DEBOUNCE_CNT+1)` bits without the macro.
- FSM states per channel: RELEASED, PRESS_CHK, PRESSED, RELEASE_CHK. Reset state is RELEASED with `cnt`=0.
- RELEASED:
  - `key_sync`=0 → PRESS_CHK, `cnt`←0.
- PRESS_CHK:
  - `key_sync`=1 → RELEASED, `cnt`←0. This is a bounce; no strobe.
  - Else if `cnt`==DEBOUNCE_CNT-1 → PRESSED, `cnt`←0, `key_stable[i]`←0, `key_press[i]` pulses.
  - Else `cnt`←`cnt`+1.
- PRESSED:
  - `key_sync`=1 → RELEASE_CHK, `cnt`←0.
  - Else the long-press counter runs (see Configuration).
- RELEASE_CHK, mirror of PRESS_CHK:
  - `key_sync`=0 → PRESSED, `cnt`←0. Long-press timing restarts from 0.
  - Else if `cnt`==DEBOUNCE_CNT-1 → RELEASED, `cnt`←0, `key_stable[i]`←1, `key_release[i]` pulses.
  - Else `cnt`←`cnt`+1.
- Strobes are registered. Each is high for exactly one cycle and low otherwise.
- `key_press` and `key_release` of the same channel are never high together.
- Several channels may strobe in the same cycle.
- `key_stable` changes only in the same cycle as the matching strobe.

## Timing
- Reset values: `key_stable`=4'b1111; `key_press`, `key_release`, `key_long`=4'b0000; synchroniser flops=1; all FSMs in RELEASED.
- Reset asserted mid-operation returns every channel to reset values immediately, with no strobe generated.
- Latency: count the first `clk` edge that samples `key_n[i]`=0 as edge 1. If the pin then stays low, `key_stable[i]` falls and `key_press[i]` is high after edge DEBOUNCE_CNT+3. Release latency is identical.
- Any opposite-level sample on `key_sync` during a CHK state aborts that check, and the full DEBOUNCE_CNT restarts on the next attempt. Glitches shorter than DEBOUNCE_CNT cycles produce no output change.
- Throughput: the minimum spacing between `key_press` and the next `key_release` on one channel is DEBOUNCE_CNT+1 cycles.

## Configuration
Macro `KEY_DEBOUNCE_LONG_EN` controls long-press detection.
- Defined:
  - In PRESSED, `cnt` increments each cycle and saturates at LONG_CNT-1.
  - On the cycle `cnt` first equals LONG_CNT-1, `key_long[i]` pulses once. The first `key_long` occurs LONG_CNT cycles after `key_press`.
  - There is no repeat while held; the next pulse requires a full release and re-press.
- Undefined:
  - `cnt` stays 0 in PRESSED, `key_long`=4'b0000 constantly, and the counter is sized for DEBOUNCE_CNT only.

## Test plan
Run the bench with DEBOUNCE_CNT=4, LONG_CNT=20.
- **Reset:** hold `rst_n`=0, toggle `key_n` randomly → `key_stable`=4'b1111 and all strobes 0 throughout; after release, `key_n`=4'b1111 gives no strobes.
- **Clean press/release:** drive `key_n`=4'b1110 from edge 1 → `key_stable`=4'b1110 and `key_press`=4'b0001 for one cycle after edge 7. Drive it back to 4'b1111 → `key_release`=4'b0001 for one cycle 7 edges later, and `key_stable` returns to 4'b1111.
- **Bounce rejection:** pulse `key_n[1]` low for 3 cycles, high for 1 cycle, repeated 5 times, then hold low → no strobe during the bounces; a single `key_press`=4'b0010 follows exactly 7 edges after the final falling sample.
- **Simultaneous keys:** drive `key_n` from 4'b1111 to 4'b0011 on the same edge → `key_press`=4'b1100 in one cycle and `key_stable`=4'b0011; bits 0 and 1 never strobe.
- **Long press** (macro defined): hold `key_n[2]` low → exactly one `key_long`=4'b0100 pulse 20 cycles after `key_press`. Hold a further 100 cycles → no repeat. With the macro undefined → `key_long` stays 0.
- **Reset mid-check:** assert `rst_n`=0 while channel 3 is in PRESS_CHK with `cnt`=2 → outputs return to reset values and no `key_press` occurs; after deassertion with the pin still low, `key_press[3]` arrives after the full 7-edge latency.
